inst_fetch_queue: RTL and testbench

- Dual-issue instruction buffer between the instruction cache fetch outputs and the decode stage.
- Each cycle it accepts 0–2 fetched instructions with their PCs and presents up to 2 of the oldest entries to decode.
- Decode consumes 0–2 entries per cycle.
- Decouples cache stalls from decode stalls; supports flush on branch redirect or exception.

---
 rtl/cpu_defs.sv | 15 +
 rtl/inst_fetch_queue.sv | 91 +++++++++
 tb/tb_inst_fetch_queue.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU front-end definitions: datapath widths and the fetch entry record
// carried from the instruction cache through the fetch queue to decode.
package cpu_defs;

  localparam int INST_W      = 32;
  localparam int PC_W        = 32;
  localparam int FETCH_WIDTH = 2;
  localparam int ISSUE_WIDTH = 2;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction buffer between the I-cache fetch outputs and decode:
// accepts 0-2 instructions per cycle and presents the two oldest to decode.
module inst_fetch_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push1,
  input  logic              push2,
  input  logic [INST_W-1:0] push_inst1,
  input  logic [INST_W-1:0] push_inst2,
  input  logic [PC_W-1:0]   push_pc1,
  input  logic              pop1,
  input  logic              pop2,
  output logic              out_valid1,
  output logic              out_valid2,
  output logic [INST_W-1:0] out_inst1,
  output logic [INST_W-1:0] out_inst2,
  output logic [PC_W-1:0]   out_pc1,
  output logic [PC_W-1:0]   out_pc2,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W:0]   cnt;
  logic [1:0]       npush_req;
  logic [1:0]       npush;
  logic [1:0]       npop;
  logic [PTR_W+1:0] free_slots;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  assign out_valid1 = (cnt != '0);
  assign out_valid2 = (cnt >= (PTR_W+1)'(2));
  assign out_inst1  = mem[head].inst;
  assign out_pc1    = mem[head].pc;
  assign out_inst2  = mem[head_p1].inst;
  assign out_pc2    = mem[head_p1].pc;
  assign full       = (cnt > (PTR_W+1)'(DEPTH - 2));
  assign empty      = (cnt == '0);
  assign count      = cnt;

  // Space freed by this cycle's pops is reusable immediately, so an
  // over-eager producer only loses the pushes that truly do not fit.
  always_comb begin
    npush_req  = {1'b0, push1} + {1'b0, push1 & push2};
    npop       = {1'b0, pop1 & out_valid1} + {1'b0, pop1 & pop2 & out_valid2};
    free_slots = (PTR_W+2)'(DEPTH) - {1'b0, cnt} + {{PTR_W{1'b0}}, npop};
    npush      = npush_req;
    if (free_slots < {{PTR_W{1'b0}}, npush_req}) begin
      npush = free_slots[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PTR_W'(npop);
      tail <= tail + PTR_W'(npush);
      cnt  <= cnt + (PTR_W+1)'(npush) - (PTR_W+1)'(npop);
    end
  end

  // NOTE: the storage array has no reset; entries are only observed when the
  // registered count marks them valid, so clearing them would be wasted logic.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (npush != 2'd0) begin
        mem[tail] <= '{inst: push_inst1, pc: push_pc1};
      end
      if (npush == 2'd2) begin
        mem[tail_p1] <= '{inst: push_inst2, pc: push_pc1 + PC_W'(4)};
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_inst_fetch_queue;
  import cpu_defs::*;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic              clk = 1'b0;
  logic              rst, flush, push1, push2, pop1, pop2;
  logic [INST_W-1:0] push_inst1, push_inst2;
  logic [PC_W-1:0]   push_pc1;
  logic              out_valid1, out_valid2, full, empty;
  logic [INST_W-1:0] out_inst1, out_inst2;
  logic [PC_W-1:0]   out_pc1, out_pc2;
  logic [PTR_W:0]    count;

  int checks   = 0;
  int failures = 0;

  fetch_entry_t model_q[$];
  bit           model_on = 1'b0;

  inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push1      (push1),
    .push2      (push2),
    .push_inst1 (push_inst1),
    .push_inst2 (push_inst2),
    .push_pc1   (push_pc1),
    .pop1       (pop1),
    .pop2       (pop2),
    .out_valid1 (out_valid1),
    .out_valid2 (out_valid2),
    .out_inst1  (out_inst1),
    .out_inst2  (out_inst2),
    .out_pc1    (out_pc1),
    .out_pc2    (out_pc2),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of entries, updated with the queue's rules.
  task automatic model_step(input logic r, f, p1, p2, q1, q2,
                            input logic [31:0] i1, i2, pc);
    int n_pop, n_push, room;
    if (r || f) begin
      model_q.delete();
      return;
    end
    n_pop = 0;
    if (q1) n_pop = q2 ? 2 : 1;
    if (n_pop > model_q.size()) n_pop = model_q.size();
    repeat (n_pop) void'(model_q.pop_front());
    n_push = 0;
    if (p1) n_push = p2 ? 2 : 1;
    room = DEPTH - model_q.size();
    if (n_push > room) n_push = room;
    if (n_push >= 1) model_q.push_back('{inst: i1, pc: pc});
    if (n_push == 2) model_q.push_back('{inst: i2, pc: pc + 32'd4});
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
  task automatic cycle(input logic r, f, p1, p2, q1, q2,
                       input logic [31:0] i1 = '0, i2 = '0, pc = '0);
    rst = r; flush = f; push1 = p1; push2 = p2; pop1 = q1; pop2 = q2;
    push_inst1 = i1; push_inst2 = i2; push_pc1 = pc;
    @(posedge clk);
    model_step(r, f, p1, p2, q1, q2, i1, i2, pc);
    if (r) model_on = 1'b1;
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (model_on) begin
      check("count", {59'd0, count}, 64'(model_q.size()));
      check("empty", {63'd0, empty}, {63'd0, model_q.size() == 0});
      check("full", {63'd0, full}, {63'd0, (DEPTH - model_q.size()) < 2});
      check("out_valid1", {63'd0, out_valid1}, {63'd0, model_q.size() >= 1});
      check("out_valid2", {63'd0, out_valid2}, {63'd0, model_q.size() >= 2});
      if (model_q.size() >= 1) begin
        check("out_inst1", {32'd0, out_inst1}, {32'd0, model_q[0].inst});
        check("out_pc1", {32'd0, out_pc1}, {32'd0, model_q[0].pc});
      end
      if (model_q.size() >= 2) begin
        check("out_inst2", {32'd0, out_inst2}, {32'd0, model_q[1].inst});
        check("out_pc2", {32'd0, out_pc2}, {32'd0, model_q[1].pc});
      end
    end
  end

  initial begin
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("rst_count", {59'd0, count}, 64'd0);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_full", {63'd0, full}, 64'd0);
    check("rst_valid1", {63'd0, out_valid1}, 64'd0);

    // Basic dual push, visible one cycle later.
    cycle(0, 0, 1, 1, 0, 0, 32'h1111_1111, 32'h2222_2222, 32'hBFC0_0000);
    check("t1_count", {59'd0, count}, 64'd2);
    check("t1_valid2", {63'd0, out_valid2}, 64'd1);
    check("t1_pc2", {32'd0, out_pc2}, 64'hBFC0_0004);
    check("t1_inst2", {32'd0, out_inst2}, 64'h2222_2222);

    // Fill towards capacity; full asserts once fewer than 2 slots remain.
    for (int k = 0; k < 6; k++)
      cycle(0, 0, 1, 1, 0, 0, 32'h3000_0000 + 32'(2*k), 32'h3000_0001 + 32'(2*k),
            32'h0040_0000 + 32'(8*k));
    check("fill14_count", {59'd0, count}, 64'd14);
    check("fill14_full", {63'd0, full}, 64'd0);
    cycle(0, 0, 1, 1, 0, 0, 32'h4444_0000, 32'h4444_0001, 32'h0050_0000);
    check("fill16_full", {63'd0, full}, 64'd1);
    // Producer violation: both pushes must be dropped, nothing corrupted.
    cycle(0, 0, 1, 1, 0, 0, 32'hDEAD_0000, 32'hDEAD_0001, 32'h0060_0000);
    check("over_count", {59'd0, count}, 64'd16);
    check("over_head", {32'd0, out_inst1}, 64'h1111_1111);
    cycle(0, 0, 0, 0, 1, 1);
    check("pop2_count", {59'd0, count}, 64'd14);
    check("pop2_full", {63'd0, full}, 64'd0);
    check("pop2_head", {32'd0, out_inst1}, 64'h3000_0000);

    // Wrap: steer tail to 15 while keeping the queue shallow.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 32'h5000_0000, 32'h0, 32'h0001_0000);
    for (int k = 0; k < 7; k++)
      cycle(0, 0, 1, 1, 1, 1, 32'h5100_0000 + 32'(2*k), 32'h5100_0001 + 32'(2*k),
            32'h0002_0000 + 32'(8*k));
    check("wrap_pre_count", {59'd0, count}, 64'd2);
    cycle(0, 0, 1, 1, 0, 0, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h8000_FFF8);
    cycle(0, 0, 0, 0, 1, 1);
    check("wrap_inst1", {32'd0, out_inst1}, 64'hAAAA_AAAA);
    check("wrap_inst2", {32'd0, out_inst2}, 64'hBBBB_BBBB);
    check("wrap_pc2", {32'd0, out_pc2}, 64'h8000_FFFC);

    // Push two and pop one at count=5.
    cycle(0, 0, 1, 1, 0, 0, 32'hC000_000C, 32'hD000_000D, 32'h0000_1000);
    cycle(0, 0, 1, 0, 0, 0, 32'hE000_000E, 32'h0, 32'h0000_2000);
    check("t4_pre_count", {59'd0, count}, 64'd5);
    cycle(0, 0, 1, 1, 1, 0, 32'hF000_000F, 32'h6000_0006, 32'h0000_3000);
    check("t4_count", {59'd0, count}, 64'd6);
    check("t4_head", {32'd0, out_inst1}, 64'hBBBB_BBBB);

    // Flush overrides simultaneous push and pop.
    cycle(0, 0, 1, 1, 0, 0, 32'h7000_0007, 32'h7000_0008, 32'h0000_4000);
    cycle(0, 0, 1, 0, 0, 0, 32'h7000_0009, 32'h0, 32'h0000_5000);
    check("t5_pre_count", {59'd0, count}, 64'd9);
    cycle(0, 1, 1, 1, 1, 0, 32'h9999_0001, 32'h9999_0002, 32'h0000_6000);
    check("flush_count", {59'd0, count}, 64'd0);
    check("flush_empty", {63'd0, empty}, 64'd1);
    check("flush_valid1", {63'd0, out_valid1}, 64'd0);
    idle();
    check("flush_idle_count", {59'd0, count}, 64'd0);

    // Double pop with a single entry: no underflow.
    cycle(0, 0, 1, 0, 0, 0, 32'h1234_5678, 32'h0, 32'h0000_7000);
    cycle(0, 0, 0, 0, 1, 1);
    check("under_count", {59'd0, count}, 64'd0);
    check("under_empty", {63'd0, empty}, 64'd1);
    cycle(0, 0, 1, 0, 0, 0, 32'h8765_4321, 32'h0, 32'h0000_8000);
    check("under_next_inst", {32'd0, out_inst1}, 64'h8765_4321);
    check("under_next_count", {59'd0, count}, 64'd1);

    // Reset wins over flush and over pushes in the same cycle.
    cycle(0, 0, 1, 1, 0, 0, 32'h2468_0000, 32'h2468_0001, 32'h0000_9000);
    cycle(1, 1, 1, 1, 0, 0, 32'h1357_0000, 32'h1357_0001, 32'h0000_A000);
    check("rst2_count", {59'd0, count}, 64'd0);
    cycle(0, 0, 1, 0, 0, 0, 32'hCAFE_F00D, 32'h0, 32'h0000_B000);
    check("rst2_inst1", {32'd0, out_inst1}, 64'hCAFE_F00D);
    check("rst2_pc1", {32'd0, out_pc1}, 64'h0000_B000);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
